// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-pin direction, synchronised inputs, atomic set/clear,
// and sticky edge-triggered interrupt status with a level irq output.
module gpio_bank #(
  parameter int N_GPIO      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       data_in,
  input  logic              rd_strobe,
  input  logic [3:0]        wr_strobe,
  output logic [31:0]       data_out,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_oe,
  output logic              irq
);

  localparam logic [2:0] A_OUT    = 3'd0;
  localparam logic [2:0] A_DIR    = 3'd1;
  localparam logic [2:0] A_IN     = 3'd2;
  localparam logic [2:0] A_IEN    = 3'd3;
  localparam logic [2:0] A_EDGE   = 3'd4;
  localparam logic [2:0] A_STATUS = 3'd5;
  localparam logic [2:0] A_SET    = 3'd6;
  localparam logic [2:0] A_CLR    = 3'd7;

  logic [N_GPIO-1:0] out_r;
  logic [N_GPIO-1:0] dir_r;
  logic [N_GPIO-1:0] ien_r;
  logic [N_GPIO-1:0] edge_sel_r;
  logic [N_GPIO-1:0] status_r;
  logic [N_GPIO-1:0] prev_r;
  logic [N_GPIO-1:0] sync_r [SYNC_STAGES];
  logic [31:0]       data_out_r;

  logic [2:0]        reg_sel_s;
  logic              wr_any_s;
  logic [31:0]       wmask_s;
  logic [31:0]       wbits_s;
  logic [N_GPIO-1:0] wmask_n_s;
  logic [N_GPIO-1:0] wbits_n_s;
  logic [N_GPIO-1:0] sync_out_s;
  logic [N_GPIO-1:0] evt_s;
  logic [N_GPIO-1:0] w1c_s;
  logic [31:0]       rdata_s;
  logic              unused_s;

  function automatic logic [31:0] zext(input logic [N_GPIO-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[N_GPIO-1:0] = v;
    return r;
  endfunction

  function automatic logic [N_GPIO-1:0] merge(input logic [N_GPIO-1:0] old_v,
                                              input logic [N_GPIO-1:0] mask,
                                              input logic [N_GPIO-1:0] bits);
    return (old_v & ~mask) | bits;
  endfunction

  assign reg_sel_s  = addr[4:2];
  assign wr_any_s   = |wr_strobe;
  assign wmask_s    = {{8{wr_strobe[3]}}, {8{wr_strobe[2]}}, {8{wr_strobe[1]}}, {8{wr_strobe[0]}}};
  assign wbits_s    = data_in & wmask_s;
  assign wmask_n_s  = wmask_s[N_GPIO-1:0];
  assign wbits_n_s  = wbits_s[N_GPIO-1:0];
  assign sync_out_s = sync_r[SYNC_STAGES-1];
  assign unused_s   = ^{addr[31:5], addr[1:0], wmask_s, wbits_s, data_in};

  // Event detect is qualified by IEN so disabled pins never reach STATUS.
  assign evt_s = ien_r & ((edge_sel_r & sync_out_s & ~prev_r) |
                          (~edge_sel_r & ~sync_out_s & prev_r));

  // Write-one-to-clear mask for STATUS, byte-masked like every other write.
  always_comb begin
    w1c_s = {N_GPIO{1'b0}};
    if (wr_any_s && (reg_sel_s == A_STATUS)) begin
      w1c_s = wbits_n_s;
    end else begin
      w1c_s = {N_GPIO{1'b0}};
    end
  end

  // Read mux; SET/CLR and the unmapped upper bits read as zero.
  always_comb begin
    rdata_s = 32'd0;
    case (reg_sel_s)
      A_OUT:    rdata_s = zext(out_r);
      A_DIR:    rdata_s = zext(dir_r);
      A_IN:     rdata_s = zext(sync_out_s);
      A_IEN:    rdata_s = zext(ien_r);
      A_EDGE:   rdata_s = zext(edge_sel_r);
      A_STATUS: rdata_s = zext(status_r);
      default:  rdata_s = 32'd0;
    endcase
  end

  // Input synchroniser and previous-sample register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {N_GPIO{1'b0}};
      prev_r <= {N_GPIO{1'b0}};
    end else begin
      sync_r[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_r <= sync_out_s;
    end
  end

  // Register file, sticky status (new event beats w1c) and registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r      <= {N_GPIO{1'b0}};
      dir_r      <= {N_GPIO{1'b0}};
      ien_r      <= {N_GPIO{1'b0}};
      edge_sel_r <= {N_GPIO{1'b0}};
      status_r   <= {N_GPIO{1'b0}};
      data_out_r <= 32'd0;
    end else begin
      status_r <= (status_r & ~w1c_s) | evt_s;
      if (rd_strobe) begin
        data_out_r <= rdata_s;
      end
      if (wr_any_s) begin
        case (reg_sel_s)
          A_OUT:   out_r      <= merge(out_r, wmask_n_s, wbits_n_s);
          A_DIR:   dir_r      <= merge(dir_r, wmask_n_s, wbits_n_s);
          A_IEN:   ien_r      <= merge(ien_r, wmask_n_s, wbits_n_s);
          A_EDGE:  edge_sel_r <= merge(edge_sel_r, wmask_n_s, wbits_n_s);
          A_SET:   out_r      <= out_r | wbits_n_s;
          A_CLR:   out_r      <= out_r & ~wbits_n_s;
          default: ;
        endcase
      end
    end
  end

  assign data_out = data_out_r;
  assign gpio_out = out_r;
  assign gpio_oe  = dir_r;
  assign irq      = |(status_r & ien_r);

endmodule

// File: tb/tb_gpio_bank.sv
// Randomised and directed checks of gpio_bank against a register-level behavioural model.
`timescale 1ns/1ps
module tb_gpio_bank;
  localparam int N  = 32;
  localparam int SS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic        rd_strobe = 1'b0;
  logic [3:0]  wr_strobe = 4'd0;
  logic [31:0] data_out;
  logic [N-1:0] gpio_in = '0;
  logic [N-1:0] gpio_out;
  logic [N-1:0] gpio_oe;
  logic        irq;

  gpio_bank #(.N_GPIO(N), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .rd_strobe(rd_strobe),
    .wr_strobe(wr_strobe), .data_out(data_out), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: registers as plain words; pin history = pin samples taken at past edges, newest first.
  logic [31:0] m_out, m_dir, m_ien, m_edge, m_status, m_dout;
  logic [31:0] hist [0:SS];
  logic [31:0] pins = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out = 0; m_dir = 0; m_ien = 0; m_edge = 0; m_status = 0; m_dout = 0;
    for (int i = 0; i <= SS; i++) hist[i] = 32'd0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return m_out;
      3'd1: return m_dir;
      3'd2: return hist[SS-1];
      3'd3: return m_ien;
      3'd4: return m_edge;
      3'd5: return m_status;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_edge_update(input logic r, input logic [3:0] w, input logic [2:0] a,
                               input logic [31:0] d);
    logic [31:0] cur, old, evt;
    cur = hist[SS-1];
    old = hist[SS];
    evt = 32'd0;
    for (int i = 0; i < N; i++) begin
      if (m_ien[i] && (m_edge[i] ? (cur[i] && !old[i]) : (!cur[i] && old[i]))) evt[i] = 1'b1;
    end
    if (r) m_dout = m_read(a);
    for (int b = 0; b < 4; b++) begin
      if (w[b]) begin
        case (a)
          3'd0: m_out[b*8 +: 8] = d[b*8 +: 8];
          3'd1: m_dir[b*8 +: 8] = d[b*8 +: 8];
          3'd3: m_ien[b*8 +: 8] = d[b*8 +: 8];
          3'd4: m_edge[b*8 +: 8] = d[b*8 +: 8];
          3'd5: m_status[b*8 +: 8] = m_status[b*8 +: 8] & ~d[b*8 +: 8];
          3'd6: m_out[b*8 +: 8] = m_out[b*8 +: 8] | d[b*8 +: 8];
          3'd7: m_out[b*8 +: 8] = m_out[b*8 +: 8] & ~d[b*8 +: 8];
          default: ;
        endcase
      end
    end
    m_status = m_status | evt;
    for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pins;
  endtask

  task automatic check_outputs();
    check("gpio_out", gpio_out, m_out);
    check("gpio_oe", gpio_oe, m_dir);
    check("irq", {31'd0, irq}, {31'd0, |(m_status & m_ien)});
    check("data_out", data_out, m_dout);
  endtask

  // One bus cycle: drive inputs after the previous edge, advance the model, sample after the edge.
  task automatic step(input logic r, input logic [3:0] w, input logic [2:0] a, input logic [31:0] d);
    logic [31:0] junk;
    junk = $urandom;
    addr = {junk[31:5], a, junk[1:0]};
    rd_strobe = r;
    wr_strobe = w;
    data_in = d;
    gpio_in = pins;
    m_edge_update(r, w, a, d);
    @(posedge clk);
    #1;
    rd_strobe = 1'b0;
    wr_strobe = 4'd0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 3'd0, 32'd0);
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b1;
    idle(2);

    // Byte-strobe write to OUT.
    step(1'b0, 4'b0101, 3'd0, 32'h11223344);
    step(1'b1, 4'd0, 3'd0, 32'd0);
    check("t2_byte_rd", data_out, 32'h00220044);

    // Atomic set / clear.
    step(1'b0, 4'hF, 3'd0, 32'h0000000F);
    step(1'b0, 4'hF, 3'd6, 32'h000000F0);
    check("t3_set", gpio_out, 32'h000000FF);
    step(1'b0, 4'hF, 3'd7, 32'h00000081);
    check("t3_clr", gpio_out, 32'h0000007E);
    step(1'b1, 4'd0, 3'd6, 32'd0);
    check("t3_rd_set", data_out, 32'd0);

    // Rising-edge interrupt latency, w1c, and ignored falling edge.
    step(1'b0, 4'hF, 3'd3, 32'h1);
    step(1'b0, 4'hF, 3'd4, 32'h1);
    pins[0] = 1'b1;
    for (int k = 1; k <= SS + 1; k++) begin
      idle(1);
      check("t4_latency", {31'd0, irq}, (k == SS + 1) ? 32'd1 : 32'd0);
    end
    step(1'b1, 4'd0, 3'd5, 32'd0);
    check("t4_status", data_out, 32'h1);
    step(1'b0, 4'hF, 3'd5, 32'h1);
    check("t4_w1c", {31'd0, irq}, 32'd0);
    pins[0] = 1'b0;
    idle(SS + 2);
    step(1'b1, 4'd0, 3'd5, 32'd0);
    check("t4_fall_ignored", data_out, 32'd0);

    // Event coinciding with w1c on the same bit: set wins.
    pins[0] = 1'b1;
    idle(SS + 2);
    pins[0] = 1'b0;
    idle(SS + 2);
    pins[0] = 1'b1;
    idle(SS);
    step(1'b0, 4'hF, 3'd5, 32'h1);
    check("t5_irq", {31'd0, irq}, 32'd1);
    step(1'b1, 4'd0, 3'd5, 32'd0);
    check("t5_status", data_out, 32'h1);

    // Read and write to OUT in the same cycle.
    step(1'b0, 4'hF, 3'd0, 32'h12);
    step(1'b1, 4'hF, 3'd0, 32'h34);
    check("t6_old", data_out, 32'h12);
    step(1'b1, 4'd0, 3'd0, 32'd0);
    check("t6_new", data_out, 32'h34);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) pins = $urandom;
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0,
           3'($urandom_range(0, 7)),
           $urandom);
    end

    // Asynchronous reset mid-run.
    step(1'b0, 4'hF, 3'd0, 32'hFF);
    step(1'b0, 4'hF, 3'd1, 32'hFF);
    step(1'b1, 4'd0, 3'd0, 32'd0);
    rst = 1'b0;
    #1;
    m_reset();
    check("rst_gpio_out", gpio_out, 32'd0);
    check("rst_gpio_oe", gpio_oe, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(SS + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
